// File: rtl/clk_run_controller_if.sv
`default_nettype none
// =============================================================================
// Interface : clk_run_controller_if
// Purpose   : Control/status bundle between a host and clk_run_controller.
// Revision  : 1.0 - initial release
// =============================================================================
interface clk_run_controller_if;
  logic [3:1]  iKEY;
  logic [7:0]  iFDIV;
  logic        iBREAK;
  logic [15:0] iRUN_CYCLES;
  logic        oCLK_EN;
  logic        oRUNNING;
  logic        oFAST;
  logic [1:0]  oHALT_CAUSE;
  logic [31:0] oCYCLES;

  modport master (
    output iKEY, iFDIV, iBREAK, iRUN_CYCLES,
    input  oCLK_EN, oRUNNING, oFAST, oHALT_CAUSE, oCYCLES
  );

  modport slave (
    input  iKEY, iFDIV, iBREAK, iRUN_CYCLES,
    output oCLK_EN, oRUNNING, oFAST, oHALT_CAUSE, oCYCLES
  );
endinterface
`default_nettype wire

// File: rtl/clk_run_controller.sv
`default_nettype none
// =============================================================================
// Module   : clk_run_controller
// Purpose  : Debounced step/run/break sequencing that issues a one-cycle
//            processor clock-enable in the iCLK_50 domain.
// Options  : CLKCTRL_CYCLE_COUNTER_EN builds the oCYCLES enable counter.
// Revision : 1.0 - initial release
// =============================================================================
module clk_run_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_SHIFT      = 18
) (
  input  wire logic           iCLK_50,
  input  wire logic           iRST_n,
  clk_run_controller_if.slave bus
);
  localparam int                c_DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE   = c_DB_W'(1);
  localparam int                c_KEY_STEP = 3;
  localparam int                c_KEY_RUN  = 2;
  localparam int                c_KEY_FAST = 1;
  localparam logic [1:0]        c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0]        c_CAUSE_USER  = 2'b01;
  localparam logic [1:0]        c_CAUSE_BREAK = 2'b10;
  localparam logic [1:0]        c_CAUSE_COUNT = 2'b11;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_BRK  = 2'd2
  } state_t;

  logic [3:1] sync1_q;
  logic [3:1] sync2_q;
  logic [3:1] key_press;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.iKEY;
      sync2_q <= sync1_q;
    end
  end

  // Counting only while the synchronized level disagrees with the committed
  // level restarts the count on every bounce of a single-bit input.
  for (genvar k = 1; k <= 3; k++) begin : g_key
    logic [c_DB_W-1:0] db_cnt_q;
    logic              level_q;
    logic              press_q;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
      if (!iRST_n) begin
        db_cnt_q <= '0;
        level_q  <= 1'b1;
        press_q  <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (sync2_q[k] == level_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == c_DB_LAST) begin
          db_cnt_q <= '0;
          level_q  <= sync2_q[k];
          press_q  <= level_q;
        end else begin
          db_cnt_q <= db_cnt_q + c_DB_ONE;
        end
      end
    end

    assign key_press[k] = press_q;
  end

  state_t      state_q, state_d;
  logic        clk_en_q, clk_en_d;
  logic        running_q;
  logic        fast_q, fast_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] remain_q, remain_d;
  logic [25:0] rate_cnt_q, rate_cnt_d;
  logic [7:0]  fdiv_eff;
  logic [25:0] period;
  logic        tick;

  assign fdiv_eff = (bus.iFDIV == 8'd0) ? 8'd1 : bus.iFDIV;
  assign period   = fast_q ? {18'd0, fdiv_eff} : ({18'd0, fdiv_eff} << SLOW_SHIFT);
  // Comparing with >= lets a shrinking divisor take effect on the next cycle.
  assign tick     = (rate_cnt_q >= (period - 26'd1));

  always_comb begin
    state_d    = state_q;
    clk_en_d   = 1'b0;
    cause_d    = cause_q;
    remain_d   = remain_q;
    fast_d     = fast_q ^ key_press[c_KEY_FAST];
    rate_cnt_d = tick ? '0 : (rate_cnt_q + 26'd1);
    if ((state_q != S_RUN) || key_press[c_KEY_FAST]) begin
      rate_cnt_d = '0;
    end

    case (state_q)
      S_HALT: begin
        if (key_press[c_KEY_STEP]) begin
          clk_en_d = 1'b1;
        end
        if (key_press[c_KEY_RUN]) begin
          if (bus.iBREAK) begin
            state_d = S_BRK;
            cause_d = c_CAUSE_BREAK;
          end else begin
            state_d  = S_RUN;
            remain_d = bus.iRUN_CYCLES;
            cause_d  = c_CAUSE_NONE;
          end
        end
      end
      S_RUN: begin
        if (bus.iBREAK) begin
          state_d = S_BRK;
          cause_d = c_CAUSE_BREAK;
        end else if (key_press[c_KEY_RUN]) begin
          state_d = S_HALT;
          cause_d = c_CAUSE_USER;
        end else if (tick) begin
          clk_en_d = 1'b1;
          if (remain_q != 16'd0) begin
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_d = S_HALT;
              cause_d = c_CAUSE_COUNT;
            end
          end
        end
      end
      S_BRK: begin
        if (!bus.iBREAK) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= S_HALT;
      clk_en_q   <= 1'b0;
      running_q  <= 1'b0;
      fast_q     <= 1'b0;
      cause_q    <= c_CAUSE_NONE;
      remain_q   <= '0;
      rate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_en_q   <= clk_en_d;
      running_q  <= (state_d == S_RUN);
      fast_q     <= fast_d;
      cause_q    <= cause_d;
      remain_q   <= remain_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end

`ifdef CLKCTRL_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      cycles_q <= '0;
    end else if (clk_en_d) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign bus.oCYCLES = cycles_q;
`else
  assign bus.oCYCLES = '0;
`endif

  assign bus.oCLK_EN     = clk_en_q;
  assign bus.oRUNNING    = running_q;
  assign bus.oFAST       = fast_q;
  assign bus.oHALT_CAUSE = cause_q;
endmodule
`default_nettype wire

// File: tb/tb_clk_run_controller.sv
`default_nettype none
// =============================================================================
// Module   : tb_clk_run_controller
// Purpose  : Self-checking bench for clk_run_controller (vector table, corner
//            sequences and randomized traffic against a behavioural model).
// Revision : 1.0 - initial release
// =============================================================================
module tb_clk_run_controller;
  localparam int c_D  = 4;
  localparam int c_SS = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   en_count;

  clk_run_controller_if bus ();

  clk_run_controller #(
    .DEBOUNCE_CYCLES(c_D),
    .SLOW_SHIFT     (c_SS)
  ) dut (
    .iCLK_50(clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 halted, 1 running, 2 held at breakpoint.
  int         m_mode;
  bit         m_fast;
  bit  [1:0]  m_cause;
  int         m_remain;
  int         m_elapsed;
  bit  [31:0] m_cycles;
  bit         m_en;
  bit  [3:1]  m_level;
  bit  [3:1]  m_pulse;
  bit  [5:0]  m_hist [1:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_fast    = 1'b0;
    m_cause   = 2'b00;
    m_remain  = 0;
    m_elapsed = 0;
    m_cycles  = 32'd0;
    m_en      = 1'b0;
    m_level   = 3'b111;
    m_pulse   = 3'b000;
    for (int k = 1; k <= 3; k++) m_hist[k] = '1;
  endtask

  task automatic model_edge();
    bit [3:1] newp;
    bit       tick;
    bit       tog;
    int       fd;
    int       p;
    // Key accepted once its synchronized samples (2 edges late) differ from
    // the committed level for c_D consecutive edges.
    for (int k = 1; k <= 3; k++) begin
      bit all_diff;
      m_hist[k] = {m_hist[k][4:0], bus.iKEY[k]};
      all_diff  = 1'b1;
      for (int j = 2; j <= c_D + 1; j++) begin
        if (m_hist[k][j] == m_level[k]) all_diff = 1'b0;
      end
      newp[k] = 1'b0;
      if (all_diff) begin
        newp[k]    = m_level[k];
        m_level[k] = ~m_level[k];
      end
    end

    fd        = (bus.iFDIV == 8'd0) ? 1 : int'(bus.iFDIV);
    p         = m_fast ? fd : fd * (1 << c_SS);
    tog       = m_pulse[1];
    tick      = (m_mode == 1) && (m_elapsed + 1 >= p);
    m_en      = 1'b0;
    m_elapsed = ((m_mode != 1) || tog || tick) ? 0 : m_elapsed + 1;
    if (tog) m_fast = ~m_fast;

    case (m_mode)
      0: begin
        if (m_pulse[3]) m_en = 1'b1;
        if (m_pulse[2]) begin
          if (bus.iBREAK) begin
            m_mode  = 2;
            m_cause = 2'b10;
          end else begin
            m_mode   = 1;
            m_remain = int'(bus.iRUN_CYCLES);
            m_cause  = 2'b00;
          end
        end
      end
      1: begin
        if (bus.iBREAK) begin
          m_mode  = 2;
          m_cause = 2'b10;
        end else if (m_pulse[2]) begin
          m_mode  = 0;
          m_cause = 2'b01;
        end else if (tick) begin
          m_en = 1'b1;
          if (m_remain != 0) begin
            m_remain--;
            if (m_remain == 0) begin
              m_mode  = 0;
              m_cause = 2'b11;
            end
          end
        end
      end
      default: begin
        if (!bus.iBREAK) m_mode = 0;
      end
    endcase
    if (m_en) m_cycles++;
    m_pulse = newp;
  endtask

  task automatic compare_model();
    logic [31:0] exp_cycles;
`ifdef CLKCTRL_CYCLE_COUNTER_EN
    exp_cycles = m_cycles;
`else
    exp_cycles = 32'd0;
`endif
    check("model_clk_en", bus.oCLK_EN, m_en);
    check("model_running", bus.oRUNNING, (m_mode == 1));
    check("model_fast", bus.oFAST, m_fast);
    check("model_cause", bus.oHALT_CAUSE, m_cause);
    check("model_cycles", bus.oCYCLES, exp_cycles);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_edge();
    if (bus.oCLK_EN) en_count++;
    compare_model();
  endtask

  task automatic hold(input logic [3:1] key, input int n);
    bus.iKEY = key;
    repeat (n) step();
  endtask

  typedef struct {
    logic [3:1]  key;
    logic [7:0]  fdiv;
    logic        brk;
    logic [15:0] runc;
    int          n;
    int          exp_en;
    logic        exp_run;
    logic        exp_fast;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int hold_k [1:3];
    int en_at;
    checks   = 0;
    failures = 0;
    en_count = 0;
    model_reset();

    // key bits {step, run, fast}, active low
    tbl[0]  = '{3'b111, 8'd3, 1'b0, 16'd0,  5, 0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{3'b110, 8'd3, 1'b0, 16'd0,  8, 0, 1'b0, 1'b1, 2'd0};
    tbl[2]  = '{3'b111, 8'd3, 1'b0, 16'd0,  8, 0, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{3'b101, 8'd3, 1'b0, 16'd0,  8, 0, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{3'b111, 8'd3, 1'b0, 16'd0, 12, 4, 1'b1, 1'b1, 2'd0};
    tbl[5]  = '{3'b101, 8'd3, 1'b0, 16'd0,  7, 2, 1'b0, 1'b1, 2'd1};
    tbl[6]  = '{3'b111, 8'd3, 1'b0, 16'd0, 10, 0, 1'b0, 1'b1, 2'd1};
    tbl[7]  = '{3'b101, 8'd1, 1'b0, 16'd5,  7, 0, 1'b1, 1'b1, 2'd0};
    tbl[8]  = '{3'b111, 8'd1, 1'b0, 16'd5, 10, 5, 1'b0, 1'b1, 2'd3};
    tbl[9]  = '{3'b101, 8'd1, 1'b1, 16'd0,  7, 0, 1'b0, 1'b1, 2'd2};
    tbl[10] = '{3'b111, 8'd1, 1'b1, 16'd0,  8, 0, 1'b0, 1'b1, 2'd2};
    tbl[11] = '{3'b111, 8'd1, 1'b0, 16'd0,  3, 0, 1'b0, 1'b1, 2'd2};
    tbl[12] = '{3'b011, 8'd1, 1'b0, 16'd0,  8, 1, 1'b0, 1'b1, 2'd2};
    tbl[13] = '{3'b111, 8'd1, 1'b0, 16'd0,  8, 0, 1'b0, 1'b1, 2'd2};
    tbl[14] = '{3'b110, 8'd1, 1'b0, 16'd0,  8, 0, 1'b0, 1'b0, 2'd2};
    tbl[15] = '{3'b111, 8'd1, 1'b0, 16'd0,  8, 0, 1'b0, 1'b0, 2'd2};
    tbl[16] = '{3'b101, 8'd1, 1'b0, 16'd2,  7, 0, 1'b1, 1'b0, 2'd0};
    tbl[17] = '{3'b111, 8'd1, 1'b0, 16'd2, 10, 2, 1'b0, 1'b0, 2'd3};

    rst_n           = 1'b1;
    bus.iKEY        = 3'b111;
    bus.iFDIV       = 8'd3;
    bus.iBREAK      = 1'b0;
    bus.iRUN_CYCLES = 16'd0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_clk_en", bus.oCLK_EN, 1'b0);
    check("reset_running", bus.oRUNNING, 1'b0);
    check("reset_fast", bus.oFAST, 1'b0);
    check("reset_cause", bus.oHALT_CAUSE, 2'b00);
    check("reset_cycles", bus.oCYCLES, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      bus.iFDIV       = tbl[i].fdiv;
      bus.iBREAK      = tbl[i].brk;
      bus.iRUN_CYCLES = tbl[i].runc;
      en_count        = 0;
      hold(tbl[i].key, tbl[i].n);
      check($sformatf("vec%0d_en_count", i), en_count, tbl[i].exp_en);
      check($sformatf("vec%0d_running", i), bus.oRUNNING, tbl[i].exp_run);
      check($sformatf("vec%0d_fast", i), bus.oFAST, tbl[i].exp_fast);
      check($sformatf("vec%0d_cause", i), bus.oHALT_CAUSE, tbl[i].exp_cause);
    end

    // Short glitch, clean press, bouncing release.
    en_count = 0;
    hold(3'b011, 3);
    hold(3'b111, 12);
    check("glitch_no_enable", en_count, 0);
    en_count = 0;
    en_at    = 0;
    bus.iKEY = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.oCLK_EN && en_at == 0) en_at = i;
    end
    check("press_enable_count", en_count, 1);
    check("press_enable_latency", en_at, 7);
    en_count = 0;
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 3'b111 : 3'b011, 1);
    hold(3'b111, 10);
    check("bounce_release_no_enable", en_count, 0);

    // Divisor 0 acts as 1; mid-run divisor shrink.
    hold(3'b110, 7);
    check("fast_toggled_on", bus.oFAST, 1'b1);
    hold(3'b111, 7);
    bus.iFDIV       = 8'd0;
    bus.iRUN_CYCLES = 16'd0;
    hold(3'b101, 7);
    check("run_entry_running", bus.oRUNNING, 1'b1);
    en_count = 0;
    hold(3'b111, 8);
    check("fdiv0_continuous", en_count, 8);
    bus.iFDIV = 8'd200;
    en_count  = 0;
    repeat (50) step();
    check("fdiv200_quiet", en_count, 0);
    bus.iFDIV = 8'd2;
    step(); check("shrink_tick_now", bus.oCLK_EN, 1'b1);
    step(); check("shrink_gap", bus.oCLK_EN, 1'b0);
    step(); check("shrink_period2", bus.oCLK_EN, 1'b1);
    step(); check("shrink_gap2", bus.oCLK_EN, 1'b0);

    // Break coinciding with a tick, presses ignored in break, resume.
    bus.iFDIV = 8'd1;
    repeat (2) step();
    check("p1_enable", bus.oCLK_EN, 1'b1);
    bus.iBREAK = 1'b1;
    step();
    check("break_no_enable", bus.oCLK_EN, 1'b0);
    check("break_running", bus.oRUNNING, 1'b0);
    check("break_cause", bus.oHALT_CAUSE, 2'b10);
    hold(3'b101, 9);
    check("break_runpress_ignored", bus.oRUNNING, 1'b0);
    check("break_runpress_cause", bus.oHALT_CAUSE, 2'b10);
    hold(3'b111, 7);
    bus.iBREAK = 1'b0;
    step();
    check("break_release_halt", bus.oRUNNING, 1'b0);
    check("break_release_cause", bus.oHALT_CAUSE, 2'b10);
    hold(3'b101, 7);
    check("resume_running", bus.oRUNNING, 1'b1);
    check("resume_cause", bus.oHALT_CAUSE, 2'b00);
    hold(3'b111, 7);

    // Asynchronous reset mid-run and mid-debounce.
    hold(3'b011, 3);
    #2;
    rst_n    = 1'b0;
    bus.iKEY = 3'b111;
    #1;
    model_reset();
    check("midrun_reset_clk_en", bus.oCLK_EN, 1'b0);
    check("midrun_reset_running", bus.oRUNNING, 1'b0);
    check("midrun_reset_fast", bus.oFAST, 1'b0);
    check("midrun_reset_cause", bus.oHALT_CAUSE, 2'b00);
    check("midrun_reset_cycles", bus.oCYCLES, 32'd0);
    repeat (3) step();
    rst_n    = 1'b1;
    en_count = 0;
    hold(3'b111, 20);
    check("post_reset_no_enable", en_count, 0);
    check("post_reset_running", bus.oRUNNING, 1'b0);

    // Randomized traffic against the model.
    for (int k = 1; k <= 3; k++) hold_k[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 1; k <= 3; k++) begin
        if (hold_k[k] == 0) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.iKEY[k] = 1'b0;
            hold_k[k]   = int'($urandom_range(1, 12));
          end else begin
            bus.iKEY[k] = 1'b1;
            hold_k[k]   = int'($urandom_range(5, 30));
          end
        end
        hold_k[k]--;
      end
      if (bus.iBREAK) begin
        if ($urandom_range(0, 4) == 0) bus.iBREAK = 1'b0;
      end else begin
        if ($urandom_range(0, 59) == 0) bus.iBREAK = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) bus.iFDIV = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) bus.iRUN_CYCLES = 16'($urandom_range(0, 6));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/clk_run_controller.md
# clk_run_controller

Sequencing controller for the processor clock. Takes the raw push-buttons, divisor, break and run-length controls and produces a single-cycle clock-enable pulse (`oCLK_EN`) in the `iCLK_50` domain; the processor advances only on that pulse. It replaces free-running divided clocks with enable-based stepping, running, breakpoint halting and bounded-length runs.

## Interface
- `DEBOUNCE_CYCLES`, 500000, stable-level cycles required to accept a key change (10 ms at 50 MHz).
- `SLOW_SHIFT`, 18, slow period = fdiv << SLOW_SHIFT cycles.
- `iCLK_50`  in  1  sole clock, 50 MHz.
- `iRST_n`  in  1  asynchronous, active-low reset.
- `iKEY`  in  3  raw active-low buttons; [3] step, [2] run/stop, [1] fast/slow (bit 0 unused here).
- `iFDIV`  in  8  rate divisor; 0 treated as 1.
- `iBREAK`  in  1  breakpoint level, synchronous to `iCLK_50`.
- `iRUN_CYCLES`  in  16  enables per run; 0 = unlimited. Sampled on RUN entry.
- `oCLK_EN`  out  1  one-cycle processor advance pulse.
- `oRUNNING`  out  1  high in RUN.
- `oFAST`  out  1  1 = fast rate, 0 = slow.
- `oHALT_CAUSE`  out  2  00 none, 01 user, 10 break, 11 count expired.
- `oCYCLES`  out  32  issued-enable count (see Configuration).

## Operation
- Key path per bit: 2-FF synchronizer, then debouncer. Counter restarts on any change of synchronized level; when it reaches DEBOUNCE_CYCLES the committed level updates. A 1→0 commit yields a one-cycle press pulse. Release generates nothing.
- Rate generator: 26-bit counter; period P = max(iFDIV,1) (fast) or max(iFDIV,1) << SLOW_SHIFT (slow). Tick when counter >= P-1, counter then clears. The counter is cleared on RUN entry and on every fast/slow toggle. `>=` makes iFDIV changes mid-run safe.
- FSM states: HALT, RUN, BRK.
- HALT: step press → `oCLK_EN` for one cycle, stay HALT. Run press with iBREAK low → RUN; load remaining = iRUN_CYCLES; cause := 00. Run press with iBREAK high → BRK, cause := 10.
- RUN: tick → `oCLK_EN`. Priority per cycle: iBREAK → BRK, cause 10, no enable; else run press → HALT, cause 01, no enable; else tick issues enable, and if remaining == 1 → HALT, cause 11 (that enable is still issued). Remaining decrements per enable only when loaded nonzero. Step presses ignored.
- BRK: no enables. iBREAK low → HALT (cause kept). Run and step presses ignored.
- Fast/slow press toggles `oFAST` in any state.
- Reset (async, any time, including mid-run/mid-debounce): state HALT, `oCLK_EN` 0, `oRUNNING` 0, `oFAST` 0, `oHALT_CAUSE` 00, `oCYCLES` 0, synchronizers and committed key levels 1 (released), all counters 0.

## Timing
- All outputs registered.
- Key press to press pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles. Press pulse to `oCLK_EN` (step) or `oRUNNING` (run): 1 cycle.
- In RUN, enables occur every P cycles. First enable P cycles after `oRUNNING` rises.
- iBREAK high in cycle N: no enable at N+1; `oRUNNING` low at N+1.
- `oCLK_EN` is never high two consecutive cycles except fast mode with P = 1, where it is continuously high.

## Configuration
- `CLKCTRL_CYCLE_COUNTER_EN` defined: `oCYCLES` is a 32-bit counter incremented on every `oCLK_EN` cycle (step or run), wrapping 0xFFFFFFFF → 0, cleared only by reset.
- Undefined: counter not built, `oCYCLES` tied to 0.

## Test plan
- DEBOUNCE_CYCLES=4: iKEY[3] low for 3 cycles, then high → no enable. Held low 10 cycles → exactly one `oCLK_EN` at 2+4+1 cycles after the falling edge; bouncing release → none.
- Fast, iFDIV=3, iRUN_CYCLES=0, run press → enables every 3 cycles; second run press → HALT, cause 01, no further enables.
- iFDIV=1, iRUN_CYCLES=5, run → exactly 5 consecutive enables, then `oRUNNING` 0, cause 11, `oCYCLES`=5.
- RUN with tick and iBREAK in the same cycle → no enable, BRK, cause 10; run press while iBREAK high is ignored; iBREAK low → HALT; next run press resumes.
- iFDIV=0 in fast mode → behaves as 1 (continuous enable); mid-run change 200→2 with counter at 50 → tick next cycle, then period 2.
- Reset asserted mid-RUN and mid-debounce → all outputs at reset values immediately; no enable after release until a new press.
